mem_responder: RTL and testbench
================================

# mem_responder

Word-organised data memory that serves load/store requests from the processor datapath: the datapath drives address (ALU result) and store data, and this block returns read data. Requests use a valid/ready handshake; responses are returned after a fixed, parameterised number of wait states, with response backpressure. It replaces the zero-latency combinational data memory so the core can be moved to a multi-cycle or stalled memory system.

## Interface
- DEPTH, 64, number of 32-bit words; power of 2, at least 2
- WAIT, 2, wait-state cycles between request acceptance and the memory access; 0..15
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_we  in  1  1 = store, 0 = load
- req_addr  in  32  byte address
- req_wdata  in  32  store data
- rsp_valid  out  1  response present
- rsp_ready  in  1  requester accepts the response
- rsp_rdata  out  32  load data; 0 for stores and errors
- rsp_err  out  1  request rejected (see Configuration); valid only with rsp_valid

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: req_ready=1. On req_valid=1, latch req_we, req_addr and req_wdata, load the wait counter with WAIT, and go to WAIT.
- WAIT: req_ready=0. If the counter is nonzero, decrement it. If the counter is 0, perform the access at this edge and go to RESP:
  - Store: mem[idx] <= wdata, rdata register <= 0.
  - Load: rdata register <= mem[idx].
- idx = addr[log2(DEPTH)+1:2]; addr[1:0] ignored for indexing.
- RESP: rsp_valid=1 and rsp_rdata/rsp_err held stable. On rsp_ready=1, go to IDLE. No new request is accepted in the same cycle.
- Only one outstanding request. req_* inputs are ignored outside IDLE.
- Memory array contents are not reset. Contents are undefined until written.

## Timing
- Reset values: req_ready=0 while reset is asserted, then 1 in IDLE. rsp_valid=0, rsp_rdata=0, rsp_err=0, state=IDLE, counter=0.
- Acceptance edge = first rising edge with state IDLE and req_valid=1.
- rsp_valid rises WAIT+1 cycles after the acceptance edge. With WAIT=0, rsp_valid is high in the cycle immediately after acceptance.
- Store commit occurs at the same edge that rsp_valid rises.
- Minimum request-to-request period: WAIT+3 cycles with rsp_ready tied to 1 (accept, WAIT+1 cycles, RESP, back to IDLE).
- rsp_ready=0 in RESP holds the response indefinitely, with all outputs unchanged.
- Reset asserted mid-operation: return to IDLE immediately. A store not yet committed is discarded. Committed contents are kept.
- Load after store to the same index returns the stored data (the store is committed before its response).

## Configuration
- MEM_ERRCHK_EN defined: a request is in error if addr[1:0]≠0 or addr ≥ 4*DEPTH. An error request still takes WAIT+1 cycles, performs no write, returns rsp_rdata=0 and rsp_err=1.
- MEM_ERRCHK_EN undefined: no checking. addr[1:0] is ignored, the index wraps modulo DEPTH, and rsp_err is tied to 0.

## Test plan
- Reset: hold reset=0 for 3 cycles → req_ready=0, rsp_valid=0, rsp_rdata=0. After reset=1, req_ready=1 on the first cycle.
- Store then load, WAIT=2: store 0xDEADBEEF to addr 0x10 → rsp_valid 3 cycles after acceptance with rdata=0. Load from 0x10 → rdata=0xDEADBEEF exactly 3 cycles after acceptance.
- Backpressure: load with rsp_ready=0 for 5 cycles → rsp_valid and rsp_rdata stable, req_ready=0. Raising rsp_ready returns the block to IDLE on the next edge.
- WAIT=0 throughput: back-to-back loads with rsp_ready=1 → one response every 3 cycles, each rsp_valid 1 cycle after its acceptance.
- Error/wrap, DEPTH=64:
  - MEM_ERRCHK_EN defined: store to 0x102 or 0x100 → rsp_err=1 and memory unchanged.
  - MEM_ERRCHK_EN undefined: store 0x5 to 0x100, then load from 0x0 → 0x5.
- Reset mid-operation: assert reset during WAIT of a store to 0x20 holding 0x1 (new data 0x2) → a subsequent load of 0x20 returns 0x1.

Source files
------------

// File: rtl/mem_responder.sv
// Word-organised data memory with valid/ready request and response handshakes and WAIT wait states.
// Optional feature: define MEM_ERRCHK_EN to reject misaligned and out-of-range addresses.
module mem_responder #(
    parameter int DEPTH = 64,
    parameter int WAIT  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int         IDX_W    = $clog2(DEPTH);
    localparam logic [3:0] WAIT_CNT = 4'(WAIT);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [31:0]       mem [DEPTH];
    logic [IDX_W-1:0]  idx;
    logic              access;
    logic              addr_bad;
    logic              mem_wr;

    assign idx = addr_q[IDX_W+1:2];

`ifdef MEM_ERRCHK_EN
    logic err_q, err_d;

    assign addr_bad = (addr_q[1:0] != 2'b00) || (addr_q >= 32'(4 * DEPTH));
    assign rsp_err  = err_q;
`else
    logic unused_addr_bits;

    // Byte offset and bits above the index are don't-care: the index simply wraps.
    assign unused_addr_bits = ^{addr_q[31:IDX_W+2], addr_q[1:0]};
    assign addr_bad         = 1'b0;
    assign rsp_err          = 1'b0;
`endif

    // NOTE: every signal gets its default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        access  = 1'b0;
`ifdef MEM_ERRCHK_EN
        err_d   = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    cnt_d   = WAIT_CNT;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    access  = 1'b1;
                    rdata_d = (we_q || addr_bad) ? '0 : mem[idx];
`ifdef MEM_ERRCHK_EN
                    err_d   = addr_bad;
`endif
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // The store commits on the same edge that moves into RESP, so a later load sees it.
    assign mem_wr = access && we_q && !addr_bad;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
`ifdef MEM_ERRCHK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
`ifdef MEM_ERRCHK_EN
            err_q   <= err_d;
`endif
        end
    end

    // NOTE: the array is deliberately not reset; committed words survive a reset pulse.
    always_ff @(posedge clk) begin
        if (mem_wr) begin
            mem[idx] <= wdata_q;
        end
    end

    assign req_ready = reset && (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: two instances (WAIT=2 and WAIT=0) checked every cycle
// against a transaction-level model, plus directed literal checks and randomized traffic.
module tb_mem_responder;

    localparam int DEPTH = 64;
    localparam int W0    = 2;
    localparam int W1    = 0;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_we    [2];
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [31:0] rsp_rdata [2];
    logic        rsp_err   [2];

    mem_responder #(.DEPTH(DEPTH), .WAIT(W0)) dut0 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
    );

    mem_responder #(.DEPTH(DEPTH), .WAIT(W1)) dut1 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    function automatic int wait_of(input int d);
        return (d == 0) ? W0 : W1;
    endfunction

    function automatic int idx_of(input logic [31:0] a);
        return int'((a >> 2) % DEPTH);
    endfunction

    function automatic bit is_err(input logic [31:0] a);
`ifdef MEM_ERRCHK_EN
        return (a[1:0] != 2'b00) || (a >= 32'(4 * DEPTH));
`else
        return 1'b0 & a[0];
`endif
    endfunction

    // Transaction-level model: response is due WAIT+1 edges after the acceptance timestamp.
    int          cyc = 0;
    bit          m_busy  [2];
    bit          m_resp  [2];
    bit          m_we    [2];
    bit          m_err   [2];
    bit          m_known [2];
    int          m_acc   [2];
    logic [31:0] m_addr  [2];
    logic [31:0] m_wdata [2];
    logic [31:0] m_rdata [2];
    logic [31:0] m_mem   [2][DEPTH];
    bit          m_wr    [2][DEPTH];

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int d = 0; d < 2; d++) begin
                m_busy[d] <= 1'b0;
                m_resp[d] <= 1'b0;
            end
        end else begin
            cyc <= cyc + 1;
            for (int d = 0; d < 2; d++) begin
                if (!m_busy[d]) begin
                    if (req_valid[d] === 1'b1) begin
                        m_busy[d]  <= 1'b1;
                        m_acc[d]   <= cyc;
                        m_we[d]    <= req_we[d];
                        m_addr[d]  <= req_addr[d];
                        m_wdata[d] <= req_wdata[d];
                    end
                end else if (m_resp[d]) begin
                    if (rsp_ready[d] === 1'b1) begin
                        m_busy[d] <= 1'b0;
                        m_resp[d] <= 1'b0;
                    end
                end else if (cyc == m_acc[d] + wait_of(d) + 1) begin
                    m_resp[d]  <= 1'b1;
                    m_err[d]   <= is_err(m_addr[d]);
                    m_known[d] <= 1'b1;
                    if (m_we[d] || is_err(m_addr[d])) begin
                        m_rdata[d] <= '0;
                    end else begin
                        m_rdata[d] <= m_mem[d][idx_of(m_addr[d])];
                        m_known[d] <= m_wr[d][idx_of(m_addr[d])];
                    end
                    if (m_we[d] && !is_err(m_addr[d])) begin
                        m_mem[d][idx_of(m_addr[d])] <= m_wdata[d];
                        m_wr[d][idx_of(m_addr[d])]  <= 1'b1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!reset) begin
                check($sformatf("dut%0d.rst_req_ready", d), 32'(req_ready[d]), 32'd0);
                check($sformatf("dut%0d.rst_rsp_valid", d), 32'(rsp_valid[d]), 32'd0);
                check($sformatf("dut%0d.rst_rsp_rdata", d), rsp_rdata[d], 32'd0);
            end else begin
                check($sformatf("dut%0d.req_ready", d), 32'(req_ready[d]), 32'(!m_busy[d]));
                check($sformatf("dut%0d.rsp_valid", d), 32'(rsp_valid[d]), 32'(m_resp[d]));
                if (m_resp[d]) begin
                    check($sformatf("dut%0d.rsp_err", d), 32'(rsp_err[d]), 32'(m_err[d]));
                    if (m_known[d])
                        check($sformatf("dut%0d.rsp_rdata", d), rsp_rdata[d], m_rdata[d]);
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic issue(input int d, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata, input bit junk, output int acc);
        int t;
        t = 0;
        req_valid[d] = 1'b1;
        req_we[d]    = we;
        req_addr[d]  = addr;
        req_wdata[d] = wdata;
        while (req_ready[d] !== 1'b1 && t < 32) begin
            tick();
            t++;
        end
        check($sformatf("dut%0d.accept_in_time", d), 32'(t < 32), 32'd1);
        tick();
        acc = cyc;
        if (junk) begin
            req_valid[d] = 1'($urandom);
            req_we[d]    = 1'($urandom);
            req_addr[d]  = $urandom;
            req_wdata[d] = $urandom;
        end else begin
            req_valid[d] = 1'b0;
        end
    endtask

    task automatic await_rsp(input int d, output int lat, output logic [31:0] data, output logic err);
        lat = 0;
        while (rsp_valid[d] !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        check($sformatf("dut%0d.rsp_in_time", d), 32'(lat < 40), 32'd1);
        data = rsp_rdata[d];
        err  = rsp_err[d];
    endtask

    task automatic txn(input int d, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                       input int hold, input bit junk,
                       output int lat, output logic [31:0] data, output logic err, output int acc);
        rsp_ready[d] = (hold == 0);
        issue(d, we, addr, wdata, junk, acc);
        await_rsp(d, lat, data, err);
        repeat (hold) tick();
        rsp_ready[d] = 1'b1;
        req_valid[d] = 1'b0;
        tick();
    endtask

    initial begin
        int          lat;
        int          acc;
        int          accs [3];
        logic [31:0] data;
        logic        err;
        int          d;
        bit          we;
        logic [31:0] a;

        for (int i = 0; i < 2; i++) begin
            req_valid[i] = 1'b0;
            req_we[i]    = 1'b0;
            req_addr[i]  = '0;
            req_wdata[i] = '0;
            rsp_ready[i] = 1'b1;
        end

        reset = 1'b0;
        repeat (3) tick();
        for (int i = 0; i < 2; i++) begin
            check($sformatf("dut%0d.reset_req_ready", i), 32'(req_ready[i]), 32'd0);
            check($sformatf("dut%0d.reset_rsp_valid", i), 32'(rsp_valid[i]), 32'd0);
            check($sformatf("dut%0d.reset_rsp_rdata", i), rsp_rdata[i], 32'd0);
        end
        reset = 1'b1;
        #1;
        check("dut0.ready_after_reset", 32'(req_ready[0]), 32'd1);
        check("dut1.ready_after_reset", 32'(req_ready[1]), 32'd1);

        txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 0, 1'b0, lat, data, err, acc);
        check("store_latency", 32'(lat), 32'd3);
        check("store_rdata", data, 32'd0);
        check("store_err", 32'(err), 32'd0);
        txn(0, 1'b0, 32'h10, 32'h0, 0, 1'b0, lat, data, err, acc);
        check("load_latency", 32'(lat), 32'd3);
        check("load_rdata", data, 32'hDEADBEEF);

        rsp_ready[0] = 1'b0;
        issue(0, 1'b0, 32'h10, 32'h0, 1'b0, acc);
        await_rsp(0, lat, data, err);
        check("bp_latency", 32'(lat), 32'd3);
        for (int k = 0; k < 5; k++) begin
            check("bp_rsp_valid", 32'(rsp_valid[0]), 32'd1);
            check("bp_rsp_rdata", rsp_rdata[0], 32'hDEADBEEF);
            check("bp_req_ready", 32'(req_ready[0]), 32'd0);
            tick();
        end
        rsp_ready[0] = 1'b1;
        tick();
        check("bp_release_req_ready", 32'(req_ready[0]), 32'd1);
        check("bp_release_rsp_valid", 32'(rsp_valid[0]), 32'd0);

`ifdef MEM_ERRCHK_EN
        txn(1, 1'b1, 32'h0, 32'h77, 0, 1'b0, lat, data, err, acc);
        txn(1, 1'b1, 32'h102, 32'hBAD, 0, 1'b0, lat, data, err, acc);
        check("err_misaligned", 32'(err), 32'd1);
        check("err_misaligned_rdata", data, 32'd0);
        txn(1, 1'b1, 32'h100, 32'hBAD, 0, 1'b0, lat, data, err, acc);
        check("err_range", 32'(err), 32'd1);
        check("err_range_latency", 32'(lat), 32'd1);
        txn(1, 1'b0, 32'h0, 32'h0, 0, 1'b0, lat, data, err, acc);
        check("err_mem_unchanged", data, 32'h77);
        check("err_clean_load", 32'(err), 32'd0);
`else
        txn(1, 1'b1, 32'h100, 32'h5, 0, 1'b0, lat, data, err, acc);
        check("wrap_store_err", 32'(err), 32'd0);
        txn(1, 1'b0, 32'h0, 32'h0, 0, 1'b0, lat, data, err, acc);
        check("wrap_load_rdata", data, 32'h5);
        check("wrap_load_err", 32'(err), 32'd0);
`endif

        for (int k = 0; k < 3; k++) begin
            txn(1, 1'b0, 32'h0, 32'h0, 0, 1'b0, lat, data, err, accs[k]);
            check("w0_latency", 32'(lat), 32'd1);
        end
        check("w0_period_a", 32'(accs[1] - accs[0]), 32'd3);
        check("w0_period_b", 32'(accs[2] - accs[1]), 32'd3);

        txn(0, 1'b1, 32'h20, 32'h1, 0, 1'b0, lat, data, err, acc);
        rsp_ready[0] = 1'b1;
        issue(0, 1'b1, 32'h20, 32'h2, 1'b0, acc);
        tick();
        reset = 1'b0;
        #1;
        check("midrst_req_ready", 32'(req_ready[0]), 32'd0);
        check("midrst_rsp_valid", 32'(rsp_valid[0]), 32'd0);
        repeat (2) tick();
        reset = 1'b1;
        #1;
        txn(0, 1'b0, 32'h20, 32'h0, 0, 1'b0, lat, data, err, acc);
        check("midrst_store_discarded", data, 32'h1);

        for (int n = 0; n < 400; n++) begin
            d  = int'($urandom_range(0, 1));
            we = 1'($urandom);
            a  = 32'($urandom_range(0, 15)) << 2;
            case ($urandom_range(0, 7))
                0: a = a | 32'($urandom_range(1, 3));
                1: a = a + 32'(4 * DEPTH);
                2: a = a | ($urandom << 8);
                default: ;
            endcase
            txn(d, we, a, $urandom, int'($urandom_range(0, 3)), 1'($urandom), lat, data, err, acc);
            check($sformatf("dut%0d.rand_latency", d), 32'(lat), 32'(wait_of(d) + 1));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
        $fatal(1, "watchdog expired");
    end

endmodule
